// File: rtl/frame_accum_pkg.sv
// Shared types and widths for the frame accumulator.
package frame_accum_pkg;

   localparam int WORD_W = 16;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_DONE  = 1'b1
   } state_t;

endpackage

// File: rtl/frame_accum_sat_add.sv
// ACC_W-bit accumulator adder with a 16-bit addend; reports the carry-out.
// With FRAME_ACCUM_SAT_EN defined the result clamps to all-ones on carry, otherwise it wraps.
module sat_add
   import frame_accum_pkg::*;
#(
   parameter int ACC_W = 20
) (
   input  logic [ACC_W-1:0]  a,
   input  logic [WORD_W-1:0] b,
   output logic [ACC_W-1:0]  sum,
   output logic              carry
);

   logic [ACC_W:0] full;

   always_comb begin
      full  = {1'b0, a} + {{(ACC_W + 1 - WORD_W){1'b0}}, b};
      carry = full[ACC_W];
`ifdef FRAME_ACCUM_SAT_EN
      sum   = carry ? '1 : full[ACC_W-1:0];
`else
      sum   = full[ACC_W-1:0];
`endif
   end

endmodule

// File: rtl/frame_accum.sv
// Groups 16-bit words into FRAME_LEN-word frames and reports each frame's sum and max.
// Define FRAME_ACCUM_SAT_EN for a saturating sum and a sticky per-frame overflow flag on ovf.
//
// state    | meaning
// ST_ACCUM | accepting words, accumulating sum/max of the current frame
// ST_DONE  | frame result held on the outputs until downstream takes it
module frame_accum
   import frame_accum_pkg::*;
#(
   parameter int FRAME_LEN = 16,
   parameter int ACC_W     = 20
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              in_valid,
   output logic              in_enable,
   input  logic [WORD_W-1:0] data_in,
   input  logic              clear,
   output logic              out_valid,
   input  logic              out_enable,
   output logic [ACC_W-1:0]  sum_out,
   output logic [WORD_W-1:0] max_out,
   output logic              ovf
);

   localparam int CNT_W = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

   state_t              state_q, state_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [WORD_W-1:0]   max_q, max_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ACC_W-1:0]    sum_out_q, sum_out_d;
   logic [WORD_W-1:0]   max_out_q, max_out_d;
   logic                out_valid_q, out_valid_d;
   logic                in_enable_q, in_enable_d;

   logic [ACC_W-1:0]    add_sum;
   logic                add_carry;
   logic [WORD_W-1:0]   max_next;

`ifdef FRAME_ACCUM_SAT_EN
   logic                sticky_q, sticky_d;
   logic                ovf_q, ovf_d;
`endif

   sat_add #(.ACC_W(ACC_W)) u_sat_add (
      .a     (acc_q),
      .b     (data_in),
      .sum   (add_sum),
      .carry (add_carry)
   );

   assign max_next = (data_in > max_q) ? data_in : max_q;

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      max_d       = max_q;
      cnt_d       = cnt_q;
      sum_out_d   = sum_out_q;
      max_out_d   = max_out_q;
      out_valid_d = out_valid_q;
      in_enable_d = in_enable_q;
`ifdef FRAME_ACCUM_SAT_EN
      sticky_d    = sticky_q;
      ovf_d       = ovf_q;
`endif

      if (clear) begin
         // Abort: any word offered this cycle and any pending result are dropped.
         state_d     = ST_ACCUM;
         acc_d       = '0;
         max_d       = '0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
         in_enable_d = 1'b1;
`ifdef FRAME_ACCUM_SAT_EN
         sticky_d    = 1'b0;
`endif
      end else begin
         case (state_q)
            ST_ACCUM: begin
               if (in_valid && in_enable_q) begin
                  if (cnt_q == CNT_LAST) begin
                     sum_out_d   = add_sum;
                     max_out_d   = max_next;
                     out_valid_d = 1'b1;
                     in_enable_d = 1'b0;
                     acc_d       = '0;
                     max_d       = '0;
                     cnt_d       = '0;
                     state_d     = ST_DONE;
`ifdef FRAME_ACCUM_SAT_EN
                     ovf_d       = sticky_q | add_carry;
                     sticky_d    = 1'b0;
`endif
                  end else begin
                     acc_d = add_sum;
                     max_d = max_next;
                     cnt_d = cnt_q + CNT_W'(1);
`ifdef FRAME_ACCUM_SAT_EN
                     sticky_d = sticky_q | add_carry;
`endif
                  end
               end
            end
            ST_DONE: begin
               if (out_valid_q && out_enable) begin
                  out_valid_d = 1'b0;
                  in_enable_d = 1'b1;
                  state_d     = ST_ACCUM;
               end
            end
            default: state_d = ST_ACCUM;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_ACCUM;
         acc_q       <= '0;
         max_q       <= '0;
         cnt_q       <= '0;
         sum_out_q   <= '0;
         max_out_q   <= '0;
         out_valid_q <= 1'b0;
         in_enable_q <= 1'b1;
`ifdef FRAME_ACCUM_SAT_EN
         sticky_q    <= 1'b0;
         ovf_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         max_q       <= max_d;
         cnt_q       <= cnt_d;
         sum_out_q   <= sum_out_d;
         max_out_q   <= max_out_d;
         out_valid_q <= out_valid_d;
         in_enable_q <= in_enable_d;
`ifdef FRAME_ACCUM_SAT_EN
         sticky_q    <= sticky_d;
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign in_enable = in_enable_q;
   assign out_valid = out_valid_q;
   assign sum_out   = sum_out_q;
   assign max_out   = max_out_q;

`ifdef FRAME_ACCUM_SAT_EN
   assign ovf = ovf_q;
`else
   // A wrapping sum has no overflow report; the adder carry goes nowhere.
   logic unused_carry;
   assign unused_carry = add_carry;
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_frame_accum.sv
// Scoreboard bench for frame_accum with FRAME_LEN=4, ACC_W=17; expected frame results
// are queued as the last word is driven and popped when out_valid is observed.
module tb_frame_accum;

   logic        clk;
   logic        rstn;
   logic        in_valid;
   logic        in_enable;
   logic [15:0] data_in;
   logic        clear;
   logic        out_valid;
   logic        out_enable;
   logic [16:0] sum_out;
   logic [15:0] max_out;
   logic        ovf;

   typedef struct {
      logic [16:0] sum;
      logic [15:0] mx;
      logic        ovf;
   } res_t;

   res_t exp_q[$];
   res_t e;
   int   n_checks = 0;
   int   n_fail   = 0;

   frame_accum #(.FRAME_LEN(4), .ACC_W(17)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_enable  (in_enable),
      .data_in    (data_in),
      .clear      (clear),
      .out_valid  (out_valid),
      .out_enable (out_enable),
      .sum_out    (sum_out),
      .max_out    (max_out),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
      $fatal(1);
   end

   function automatic res_t mk(input logic [16:0] s, input logic [15:0] m, input logic o);
      res_t r;
      r.sum = s;
      r.mx  = m;
      r.ovf = o;
      return r;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; in_valid = 1'b0; data_in = '0; clear = 1'b0; out_enable = 1'b0;
      #12;
      n_checks++; if (in_enable !== 1'b1) begin n_fail++; $display("FAIL reset_in_enable: got %b want 1", in_enable); end
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_checks++; if (sum_out !== 17'd0) begin n_fail++; $display("FAIL reset_sum: got %h want 0", sum_out); end
      n_checks++; if (max_out !== 16'd0) begin n_fail++; $display("FAIL reset_max: got %h want 0", max_out); end
      n_checks++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
      rstn = 1'b1;
      cyc();
   endtask

   task automatic test_basic();
      int ov_cnt = 0;
      int ie_low = 0;
      out_enable = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; data_in = 16'(i);
         if (i == 4) exp_q.push_back(mk(17'd10, 16'd4, 1'b0));
         cyc();
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b want 1", out_valid); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++; if (sum_out !== e.sum) begin n_fail++; $display("FAIL basic_sum: got %h want %h", sum_out, e.sum); end
         n_checks++; if (max_out !== e.mx) begin n_fail++; $display("FAIL basic_max: got %h want %h", max_out, e.mx); end
         n_checks++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL basic_ovf: got %b want %b", ovf, e.ovf); end
      end
      for (int c = 0; c < 6; c++) begin
         ov_cnt += int'(out_valid);
         ie_low += int'(!in_enable);
         cyc();
      end
      n_checks++; if (ov_cnt != 1) begin n_fail++; $display("FAIL basic_valid_pulse: got %0d cycles want 1", ov_cnt); end
      n_checks++; if (ie_low != 1) begin n_fail++; $display("FAIL basic_in_enable_low: got %0d cycles want 1", ie_low); end
   endtask

   task automatic test_back_pressure();
      out_enable = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         in_valid = 1'b1; data_in = 16'(i * 10);
         if (i == 4) exp_q.push_back(mk(17'd100, 16'd40, 1'b0));
         cyc();
      end
      in_valid = 1'b1; data_in = 16'h0055;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      for (int c = 0; c < 10; c++) begin
         n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid c=%0d: got %b want 1", c, out_valid); end
         n_checks++; if (in_enable !== 1'b0) begin n_fail++; $display("FAIL bp_in_enable c=%0d: got %b want 0", c, in_enable); end
         n_checks++; if (sum_out !== e.sum) begin n_fail++; $display("FAIL bp_sum c=%0d: got %h want %h", c, sum_out, e.sum); end
         n_checks++; if (max_out !== e.mx) begin n_fail++; $display("FAIL bp_max c=%0d: got %h want %h", c, max_out, e.mx); end
         cyc();
      end
      out_enable = 1'b1;
      cyc();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
      n_checks++; if (in_enable !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_enable: got %b want 1", in_enable); end
      n_checks++; if (sum_out !== 17'd100) begin n_fail++; $display("FAIL bp_sum_kept: got %h want %h", sum_out, 17'd100); end
      for (int i = 2; i <= 5; i++) begin
         in_valid = 1'b1; data_in = 16'(i);
         if (i == 5) exp_q.push_back(mk(17'd14, 16'd5, 1'b0));
         cyc();
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++; if (sum_out !== e.sum) begin n_fail++; $display("FAIL bp_next_sum: got %h want %h", sum_out, e.sum); end
         n_checks++; if (max_out !== e.mx) begin n_fail++; $display("FAIL bp_next_max: got %h want %h", max_out, e.mx); end
      end
      cyc();
   endtask

   task automatic test_gapped();
      logic [15:0] words [4];
      words[0] = 16'h8000; words[1] = 16'h0001; words[2] = 16'hFFFF; words[3] = 16'h0010;
      out_enable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; data_in = words[i];
         if (i == 3) exp_q.push_back(mk(17'h18010, 16'hFFFF, 1'b0));
         cyc();
         if (i == 3) begin
            n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid: got %b want 1", out_valid); end
            if (out_valid === 1'b1 && exp_q.size() > 0) begin
               e = exp_q.pop_front();
               n_checks++; if (sum_out !== e.sum) begin n_fail++; $display("FAIL gap_sum: got %h want %h", sum_out, e.sum); end
               n_checks++; if (max_out !== e.mx) begin n_fail++; $display("FAIL gap_max: got %h want %h", max_out, e.mx); end
            end
         end
         in_valid = 1'b0; data_in = 16'($urandom);
         cyc();
      end
   endtask

   task automatic test_clear();
      out_enable = 1'b1;
      in_valid = 1'b1; data_in = 16'd100; cyc();
      data_in = 16'd200; cyc();
      clear = 1'b1; data_in = 16'd300; cyc();
      clear = 1'b0;
      for (int i = 0; i < 4; i++) begin
         data_in = 16'd5;
         if (i == 3) exp_q.push_back(mk(17'd20, 16'd5, 1'b0));
         cyc();
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_valid: got %b want 1", out_valid); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++; if (sum_out !== e.sum) begin n_fail++; $display("FAIL clr_sum: got %h want %h", sum_out, e.sum); end
         n_checks++; if (max_out !== e.mx) begin n_fail++; $display("FAIL clr_max: got %h want %h", max_out, e.mx); end
      end
      cyc();
      // A held result is dropped by clear.
      out_enable = 1'b0;
      in_valid = 1'b1; data_in = 16'd1;
      for (int i = 0; i < 4; i++) cyc();
      in_valid = 1'b0;
      cyc();
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_hold_valid: got %b want 1", out_valid); end
      clear = 1'b1; cyc(); clear = 1'b0;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_drop_valid: got %b want 0", out_valid); end
      n_checks++; if (in_enable !== 1'b1) begin n_fail++; $display("FAIL clr_drop_in_enable: got %b want 1", in_enable); end
      out_enable = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_in = 16'd2;
         if (i == 3) exp_q.push_back(mk(17'd8, 16'd2, 1'b0));
         cyc();
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL clr_after_valid: got %b want 1", out_valid); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++; if (sum_out !== e.sum) begin n_fail++; $display("FAIL clr_after_sum: got %h want %h", sum_out, e.sum); end
         n_checks++; if (max_out !== e.mx) begin n_fail++; $display("FAIL clr_after_max: got %h want %h", max_out, e.mx); end
      end
      cyc();
   endtask

   task automatic test_overflow();
      out_enable = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_in = 16'hFFFF;
`ifdef FRAME_ACCUM_SAT_EN
         if (i == 3) exp_q.push_back(mk(17'h1FFFF, 16'hFFFF, 1'b1));
`else
         if (i == 3) exp_q.push_back(mk(17'h1FFFC, 16'hFFFF, 1'b0));
`endif
         cyc();
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b want 1", out_valid); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++; if (sum_out !== e.sum) begin n_fail++; $display("FAIL ovf_sum: got %h want %h", sum_out, e.sum); end
         n_checks++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL ovf_flag: got %b want %b", ovf, e.ovf); end
      end
      cyc();
      // Sticky flag must not leak into the next frame.
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_in = 16'd1;
         if (i == 3) exp_q.push_back(mk(17'd4, 16'd1, 1'b0));
         cyc();
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_next_valid: got %b want 1", out_valid); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++; if (sum_out !== e.sum) begin n_fail++; $display("FAIL ovf_next_sum: got %h want %h", sum_out, e.sum); end
         n_checks++; if (ovf !== e.ovf) begin n_fail++; $display("FAIL ovf_next_flag: got %b want %b", ovf, e.ovf); end
      end
      cyc();
   endtask

   task automatic test_async_reset();
      out_enable = 1'b0;
      in_valid = 1'b1; data_in = 16'd7;
      for (int i = 0; i < 4; i++) cyc();
      in_valid = 1'b0;
      n_checks++; if (sum_out !== 17'd28) begin n_fail++; $display("FAIL ar_hold_sum: got %h want %h", sum_out, 17'd28); end
      #3 rstn = 1'b0;
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", out_valid); end
      n_checks++; if (in_enable !== 1'b1) begin n_fail++; $display("FAIL ar_in_enable: got %b want 1", in_enable); end
      n_checks++; if (sum_out !== 17'd0) begin n_fail++; $display("FAIL ar_sum: got %h want 0", sum_out); end
      n_checks++; if (max_out !== 16'd0) begin n_fail++; $display("FAIL ar_max: got %h want 0", max_out); end
      #1 rstn = 1'b1;
      cyc();
      out_enable = 1'b1;
      in_valid = 1'b1; data_in = 16'd7;
      cyc(); cyc();
      in_valid = 1'b0;
      #3 rstn = 1'b0;
      #2 rstn = 1'b1;
      cyc();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_midframe_valid: got %b want 0", out_valid); end
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         data_in = 16'd7;
         if (i == 3) exp_q.push_back(mk(17'd28, 16'd7, 1'b0));
         cyc();
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_frame_valid: got %b want 1", out_valid); end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         n_checks++; if (sum_out !== e.sum) begin n_fail++; $display("FAIL ar_frame_sum: got %h want %h", sum_out, e.sum); end
         n_checks++; if (max_out !== e.mx) begin n_fail++; $display("FAIL ar_frame_max: got %h want %h", max_out, e.mx); end
      end
      cyc();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_pressure();
      test_gapped();
      test_clear();
      test_overflow();
      test_async_reset();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d results left want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
